// File: rtl/player_motion_ctl_if.sv
// rtl/player_motion_ctl_if.sv - frame control inputs and position/status outputs of one player model
interface player_motion_ctl_if;
  logic       frame_tick;
  logic       left;
  logic       right;
  logic       jump;
  logic [1:0] coll;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       on_ground;
  logic       busy;
  logic       overrun;

  // game logic / platform checker side
  modport master (
    output frame_tick,
    output left,
    output right,
    output jump,
    output coll,
    input  x_pos,
    input  y_pos,
    input  on_ground,
    input  busy,
    input  overrun
  );

  // motion engine side
  modport slave (
    input  frame_tick,
    input  left,
    input  right,
    input  jump,
    input  coll,
    output x_pos,
    output y_pos,
    output on_ground,
    output busy,
    output overrun
  );
endinterface

// File: rtl/player_motion_ctl.sv
// rtl/player_motion_ctl.sv - per-frame 1 px/cycle movement and gravity engine for one player model
// Horizontal steps first, then vertical steps, then a one-cycle mode/velocity update.
module player_motion_ctl #(
  parameter logic [9:0] X_INIT  = 10'd100,
  parameter logic [9:0] Y_INIT  = 10'd100,
  parameter int         WIDTH   = 32,
  parameter int         HEIGHT  = 48,
  parameter int         STEP_X  = 4,
  parameter int         JUMP_V0 = 12,
  parameter int         V_MAX   = 10,
  parameter int         G_DIV   = 2
) (
  input  logic                clk,
  input  logic                rst,
  player_motion_ctl_if.slave  bus
);

  localparam int V_TOP = (JUMP_V0 > V_MAX) ? JUMP_V0 : V_MAX;
  localparam int VW    = $clog2(V_TOP + 1);
  localparam int HW    = $clog2(STEP_X + 1);
  localparam int FW    = (G_DIV > 1) ? $clog2(G_DIV) : 1;

  // Rightmost legal left edge and lowest legal top edge, in 11-bit position math.
  localparam logic [10:0] X_MAX = 11'(1023 - WIDTH);
  localparam logic [10:0] Y_MAX = 11'(767 - HEIGHT);
  localparam logic [FW-1:0] F_LAST = FW'(G_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HSTEP,
    S_VSTEP,
    S_UPDATE
  } step_t;

  typedef enum logic [1:0] {
    M_GROUND,
    M_RISE,
    M_FALL
  } mode_t;

  typedef enum logic [1:0] {
    D_NONE,
    D_LEFT,
    D_RIGHT
  } dir_t;

  step_t         step_q, step_d;
  mode_t         mode_q, mode_d;
  dir_t          dir_q, dir_d;
  dir_t          side_blk_q, side_blk_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [VW-1:0] vel_q, vel_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          chk_q, chk_d;
  logic          jump_armed_q, jump_armed_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  logic [10:0]   x11;
  logic [10:0]   y11;
  logic [HW-1:0] hrem;
  logic          grav;

  assign x11 = {1'b0, x_q};
  assign y11 = {1'b0, y_q};

  // State registers; an asserted rst abandons any partial frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q       <= S_IDLE;
      mode_q       <= M_FALL;
      dir_q        <= D_NONE;
      side_blk_q   <= D_NONE;
      x_q          <= X_INIT;
      y_q          <= Y_INIT;
      vel_q        <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      chk_q        <= 1'b0;
      jump_armed_q <= 1'b1;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      step_q       <= step_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      side_blk_q   <= side_blk_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vel_q        <= vel_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      chk_q        <= chk_d;
      jump_armed_q <= jump_armed_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      fcnt_q       <= fcnt_d;
    end
  end

  // Step sequencer and mode FSM: next state, position steps and velocity update.
  always_comb begin
    step_d       = step_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    side_blk_d   = side_blk_q;
    x_d          = x_q;
    y_d          = y_q;
    vel_d        = vel_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    chk_d        = chk_q;
    jump_armed_d = jump_armed_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    fcnt_d       = fcnt_q;
    hrem         = hcnt_q;
    grav         = 1'b0;

    // A tick that lands mid-frame is dropped, but remembered until reset.
    if (bus.frame_tick && busy_q) begin
      overrun_d = 1'b1;
    end

    case (step_q)
      S_IDLE: begin
        if (bus.frame_tick) begin
          if (bus.left ^ bus.right) begin
            dir_d  = bus.right ? D_RIGHT : D_LEFT;
            hcnt_d = HW'(STEP_X);
          end else begin
            dir_d  = D_NONE;
            hcnt_d = '0;
          end
          vcnt_d = (mode_q == M_GROUND) ? '0 : vel_q;
          chk_d  = 1'b0;
          busy_d = 1'b1;
          step_d = S_HSTEP;
        end
      end

      S_HSTEP: begin
        // coll now reflects the position produced by the previous step.
        if (chk_q) begin
          chk_d = 1'b0;
          if (bus.coll == 2'b11) begin
            side_blk_d = dir_q;
            hrem       = '0;
          end else begin
            side_blk_d = D_NONE;
          end
        end
        hcnt_d = hrem;
        if (hrem != '0) begin
          if (bus.coll == 2'b11 && side_blk_q == dir_q) begin
            hcnt_d = '0;
          end else if (dir_q == D_RIGHT && x11 >= X_MAX) begin
            hcnt_d = '0;
          end else if (dir_q == D_LEFT && x11 <= 11'd1) begin
            hcnt_d = '0;
          end else if (dir_q == D_RIGHT) begin
            x_d    = x_q + 10'd1;
            hcnt_d = hrem - HW'(1);
            chk_d  = 1'b1;
          end else if (dir_q == D_LEFT) begin
            x_d    = x_q - 10'd1;
            hcnt_d = hrem - HW'(1);
            chk_d  = 1'b1;
          end else begin
            hcnt_d = '0;
          end
        end
        if (hcnt_d == '0 && !chk_d) begin
          step_d = S_VSTEP;
        end
      end

      S_VSTEP: begin
        // Side contact (11) never matches the 10/01 tests, so it is ignored here.
        if (vcnt_q != '0) begin
          case (mode_q)
            M_FALL: begin
              if (bus.coll == 2'b10 || y11 == Y_MAX) begin
                mode_d = M_GROUND;
                vel_d  = '0;
                vcnt_d = '0;
              end else begin
                y_d    = y_q + 10'd1;
                vcnt_d = vcnt_q - VW'(1);
              end
            end
            M_RISE: begin
              if (bus.coll == 2'b01 || y11 == 11'd1) begin
                mode_d = M_FALL;
                vel_d  = '0;
                vcnt_d = '0;
              end else begin
                y_d    = y_q - 10'd1;
                vcnt_d = vcnt_q - VW'(1);
              end
            end
            default: begin
              vcnt_d = '0;
            end
          endcase
        end
        if (vcnt_d == '0) begin
          step_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        step_d = S_IDLE;
        busy_d = 1'b0;
        grav   = (fcnt_q == F_LAST);
        fcnt_d = grav ? '0 : fcnt_q + FW'(1);
        case (mode_q)
          M_GROUND: begin
            if (bus.coll != 2'b10 && y11 != Y_MAX) begin
              mode_d = M_FALL;
              vel_d  = '0;
            end else if (bus.jump && jump_armed_q) begin
              mode_d       = M_RISE;
              vel_d        = VW'(JUMP_V0);
              jump_armed_d = 1'b0;
            end
          end
          M_RISE: begin
            if (grav) begin
              if (vel_q <= VW'(1)) begin
                vel_d  = '0;
                mode_d = M_FALL;
              end else begin
                vel_d = vel_q - VW'(1);
              end
            end
          end
          M_FALL: begin
            if (grav && vel_q < VW'(V_MAX)) begin
              vel_d = vel_q + VW'(1);
            end
          end
          default: begin
            mode_d = M_FALL;
          end
        endcase
        // Releasing jump re-arms it, so a held button cannot chain jumps.
        if (!bus.jump) begin
          jump_armed_d = 1'b1;
        end
      end

      default: begin
        step_d = S_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.x_pos     = x_q;
  assign bus.y_pos     = y_q;
  assign bus.on_ground = (mode_q == M_GROUND);
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_player_motion_ctl.sv
// tb/tb_player_motion_ctl.sv - scoreboard bench for player_motion_ctl with a modelled platform checker
module tb_player_motion_ctl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   coll_mode = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   frame_no = 0;
  logic busy_prev = 1'b0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       gnd;
    logic       ovr;
    logic       chk;
    int         tag;
  } exp_t;

  exp_t exp_q[$];

  player_motion_ctl_if bus ();

  player_motion_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Platform checker stand-in: 1 = platform top at y=400 for x<150, 2 = wall at x>=110.
  always_comb begin
    bus.coll = 2'b00;
    case (coll_mode)
      1: if ((bus.y_pos + 10'd48) == 10'd400 && bus.x_pos < 10'd150) bus.coll = 2'b10;
      2: if (bus.x_pos >= 10'd110) bus.coll = 2'b11;
      default: bus.coll = 2'b00;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_frame_end: got a frame end, expected none queued");
      return;
    end
    e = exp_q.pop_front();
    if (e.chk) begin
      check($sformatf("f%0d_x", e.tag), int'(bus.x_pos), int'(e.x));
      check($sformatf("f%0d_y", e.tag), int'(bus.y_pos), int'(e.y));
      check($sformatf("f%0d_on_ground", e.tag), int'(bus.on_ground), int'(e.gnd));
      check($sformatf("f%0d_overrun", e.tag), int'(bus.overrun), int'(e.ovr));
    end
  endtask

  // Monitor: every busy 1->0 transition is a completed frame to score.
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !bus.busy) check_frame();
      busy_prev = bus.busy;
    end
  end

  task automatic frame(input int ex, input int ey, input logic eg, input logic eo,
                       input logic ec, input logic dbl);
    exp_t e;
    int   n;
    frame_no++;
    e.x   = 10'(ex);
    e.y   = 10'(ey);
    e.gnd = eg;
    e.ovr = eo;
    e.chk = ec;
    e.tag = frame_no;
    exp_q.push_back(e);
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    if (dbl) begin
      @(posedge clk); #1;
    end
    bus.frame_tick = 1'b0;
    n = 0;
    while (bus.busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (bus.busy) begin
      n_fail++;
      $display("FAIL f%0d_timeout: busy=1 after %0d cycles, expected 0", frame_no, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200_000_0;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int ey;
    logic c;
    bus.frame_tick = 1'b0;
    bus.left       = 1'b0;
    bus.right      = 1'b0;
    bus.jump       = 1'b0;
    #2;
    do_reset();

    check("rst_x", int'(bus.x_pos), 100);
    check("rst_y", int'(bus.y_pos), 100);
    check("rst_on_ground", int'(bus.on_ground), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);

    // Free fall from y=100 to the screen floor at 767-48=719.
    for (int f = 1; f <= 73; f++) begin
      c = 1'b1;
      case (f)
        1: ey = 100;
        2: ey = 100;
        3: ey = 101;
        4: ey = 102;
        10: ey = 120;
        20: ey = 190;
        21: ey = 200;
        72: ey = 710;
        73: ey = 719;
        default: begin
          ey = 0;
          c = 1'b0;
        end
      endcase
      frame(100, ey, (f == 73), 1'b0, c, 1'b0);
    end

    // Walk right on the floor, then both directions held.
    bus.right = 1'b1;
    for (int k = 1; k <= 5; k++) frame(100 + 4 * k, 719, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.left = 1'b1;
    frame(120, 719, 1'b1, 1'b0, 1'b1, 1'b0);

    // Right edge clamp at 991, then left edge clamp at 1.
    bus.left = 1'b0;
    for (int k = 1; k <= 220; k++) begin
      v = 120 + 4 * k;
      if (v > 991) v = 991;
      frame(v, 719, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    bus.right = 1'b0;
    bus.left  = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      v = 991 - 4 * k;
      if (v < 1) v = 1;
      frame(v, 719, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    bus.left = 1'b0;

    // Jump: armed at UPDATE, first airborne frame rises 12; held jump does not re-fire.
    bus.jump = 1'b1;
    frame(1, 719, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(1, 707, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 80; k++) frame(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1, 719, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.jump = 1'b0;
    frame(1, 719, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.jump = 1'b1;
    frame(1, 719, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.jump = 1'b0;
    frame(1, 707, 1'b0, 1'b0, 1'b1, 1'b0);

    // Land exactly on a platform top at y=400 (y_pos=352), then walk off its edge.
    do_reset();
    coll_mode = 1;
    for (int f = 1; f <= 37; f++) begin
      if (f == 36) frame(100, 350, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (f == 37) frame(100, 352, 1'b1, 1'b0, 1'b1, 1'b0);
      else frame(100, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    frame(100, 352, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.right = 1'b1;
    for (int m = 1; m <= 13; m++) begin
      if (m == 13) frame(152, 352, 1'b0, 1'b0, 1'b1, 1'b0);
      else frame(100 + 4 * m, 352, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    bus.right = 1'b0;

    // Side wall at x>=110: freeze on contact, move away to the left, then an overrun tick.
    do_reset();
    coll_mode = 2;
    bus.right = 1'b1;
    frame(104, 100, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(108, 100, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(110, 101, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(110, 102, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.right = 1'b0;
    bus.left  = 1'b1;
    frame(106, 104, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(102, 106, 1'b0, 1'b1, 1'b1, 1'b1);

    // Mid-frame reset discards the partial frame.
    coll_mode = 0;
    bus.left  = 1'b0;
    bus.right = 1'b1;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_x", int'(bus.x_pos), 100);
    check("midrst_y", int'(bus.y_pos), 100);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    check("midrst_on_ground", int'(bus.on_ground), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame(104, 100, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
